// File: rtl/fetch_sender_pkg.sv
// fetch_sender_pkg: shared beat type, FSM states and redirect priority for the fetch front end.
package fetch_sender_pkg;
  localparam int unsigned FS_PC_BITS = 32;
  localparam int unsigned FS_INSTR_BITS = 32;
  typedef struct packed {
    logic [FS_PC_BITS-1:0] pc;
    logic [FS_INSTR_BITS-1:0] instr;
    logic taken;
  } fetch_beat_t;
  typedef enum logic [1:0] {RUN, WAIT_TARGET, HALT} fetch_state_e;
  typedef enum logic [2:0] {RD_NONE, RD_FLUSH, RD_INVALID, RD_MISPRED, RD_TARGET} redirect_e;
  function automatic redirect_e redirect_sel(input logic flush, input logic inv, input logic mis, input logic tgt);
    return flush ? RD_FLUSH : inv ? RD_INVALID : mis ? RD_MISPRED : tgt ? RD_TARGET : RD_NONE;
  endfunction
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != '1) ? v + 32'd1 : v;
  endfunction
endpackage

// File: rtl/fetch_sender_fifo.sv
// fetch_fifo: synchronous power-of-two FIFO with clear; head is read straight from storage.
module fetch_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   cnt
);
  localparam int unsigned AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
    end else begin
      if (push) mem[wr_ptr] <= din;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/fetch_sender.sv
// fetch_sender: fetch PC generation, in-order I-cache requests, response buffering and decode redirects.
// Define FETCH_SENDER_PERF_EN to add saturating perf counters on perf_o.
module fetch_sender import fetch_sender_pkg::*; #(
  parameter int unsigned PC_BITS = FS_PC_BITS,
  parameter int unsigned INSTR_BITS = FS_INSTR_BITS,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [PC_BITS-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ic_req_valid,
  input  logic                  ic_req_ready,
  output logic [PC_BITS-1:0]    ic_req_addr,
  input  logic                  ic_resp_valid,
  input  logic [INSTR_BITS-1:0] ic_resp_data,
  input  logic                  pred_taken,
  input  logic [PC_BITS-1:0]    pred_target,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [PC_BITS-1:0]    pc_o,
  output logic [INSTR_BITS-1:0] instruction_o,
  output logic                  taken_branch_o,
  input  logic                  invalid_instruction,
  input  logic                  invalid_prediction,
  input  logic                  is_return,
  input  logic                  is_jumpl,
  input  logic [PC_BITS-1:0]    old_pc,
  input  logic                  must_flush,
  input  logic [PC_BITS-1:0]    correct_address
`ifdef FETCH_SENDER_PERF_EN
  ,
  output logic [95:0]           perf_o
`endif
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_e state;
  redirect_e redir;
  logic [PC_BITS-1:0] fetch_pc;
  logic [CW-1:0] inflight, drop_cnt, fifo_cnt, tag_cnt;
  logic [PC_BITS:0] tag_out;
  fetch_beat_t beat_in, head;
  logic hs_out, redirect, req_hs, resp_dec, resp_take;
  assign valid_o = state == RUN && fifo_cnt != '0;
  assign hs_out = valid_o & ready_i;
  assign redir = redirect_sel(must_flush, hs_out & invalid_instruction, hs_out & invalid_prediction,
                              hs_out & (is_return | is_jumpl));
  assign redirect = redir != RD_NONE;
  // Dropping valid on a redirect keeps the cache from accepting a stale-path request
  assign ic_req_valid = ~rst && state == RUN && !redirect && (fifo_cnt + inflight) < CW'(FIFO_DEPTH);
  assign ic_req_addr = fetch_pc;
  assign req_hs = ic_req_valid & ic_req_ready;
  assign resp_dec = ic_resp_valid && inflight != '0;
  assign resp_take = resp_dec && drop_cnt == '0 && !redirect && tag_cnt != '0;
  assign beat_in = '{pc: tag_out[PC_BITS:1], instr: ic_resp_data, taken: tag_out[0]};
  assign pc_o = head.pc;
  assign instruction_o = head.instr;
  assign taken_branch_o = head.taken;
  fetch_fifo #(.WIDTH(PC_BITS + 1), .DEPTH(FIFO_DEPTH)) u_tag (
    .clk(clk), .rst(rst), .clr(redirect), .push(req_hs), .din({fetch_pc, pred_taken}),
    .pop(resp_take), .dout(tag_out), .cnt(tag_cnt)
  );
  fetch_fifo #(.WIDTH($bits(fetch_beat_t)), .DEPTH(FIFO_DEPTH)) u_beat (
    .clk(clk), .rst(rst), .clr(redirect), .push(resp_take), .din(beat_in),
    .pop(hs_out), .dout(head), .cnt(fifo_cnt)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + CW'(req_hs) - CW'(resp_dec);
      drop_cnt <= redirect ? inflight - CW'(resp_dec) : drop_cnt - CW'(resp_dec && drop_cnt != '0);
      if (redir == RD_FLUSH) begin
        state <= RUN;
        fetch_pc <= correct_address;
      end else if (redir == RD_INVALID) state <= HALT;
      else if (redir == RD_MISPRED) fetch_pc <= old_pc + PC_BITS'(4);
      else if (redir == RD_TARGET) state <= WAIT_TARGET;
      else if (req_hs) fetch_pc <= pred_taken ? pred_target : fetch_pc + PC_BITS'(4);
    end
`ifdef FETCH_SENDER_PERF_EN
  logic [31:0] perf_fetched, perf_dropped, perf_redirects;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
      perf_redirects <= '0;
    end else begin
      perf_fetched <= sat_inc(perf_fetched, hs_out);
      perf_dropped <= sat_inc(perf_dropped, resp_dec && !resp_take);
      perf_redirects <= sat_inc(perf_redirects, redirect);
    end
  assign perf_o = {perf_redirects, perf_dropped, perf_fetched};
`endif
endmodule

// File: tb/tb_fetch_sender.sv
// tb_fetch_sender: directed checks of fetch_sender with an in-order 1-cycle cache model.
module tb_fetch_sender;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic ic_req_valid, ic_req_ready = 0, ic_resp_valid = 0, pred_taken = 0;
  logic [31:0] ic_req_addr, ic_resp_data = '0, pred_target = '0;
  logic valid_o, ready_i = 0, taken_branch_o;
  logic [31:0] pc_o, instruction_o;
  logic invalid_instruction = 0, invalid_prediction = 0, is_return = 0, is_jumpl = 0, must_flush = 0;
  logic [31:0] old_pc = '0, correct_address = '0;
`ifdef FETCH_SENDER_PERF_EN
  logic [95:0] perf_o;
`endif
  typedef struct packed {logic [31:0] pc; logic [31:0] instr; logic taken;} beat_t;
  beat_t beat_log[$];
  logic [31:0] req_log[$], pending[$];
  logic resp_en = 1, pred_on = 0;
  logic [31:0] pred_pc = '0, pred_tgt = '0;
  int tests = 0, fails = 0;

  fetch_sender dut (
    .clk(clk), .rst(rst), .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready),
    .ic_req_addr(ic_req_addr), .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .pred_taken(pred_taken), .pred_target(pred_target), .valid_o(valid_o), .ready_i(ready_i),
    .pc_o(pc_o), .instruction_o(instruction_o), .taken_branch_o(taken_branch_o),
    .invalid_instruction(invalid_instruction), .invalid_prediction(invalid_prediction),
    .is_return(is_return), .is_jumpl(is_jumpl), .old_pc(old_pc), .must_flush(must_flush),
    .correct_address(correct_address)
`ifdef FETCH_SENDER_PERF_EN
    , .perf_o(perf_o)
`endif
  );

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic tick();
    logic hs;
    logic [31:0] a, dummy;
    beat_t b;
    @(negedge clk);
    pred_taken = pred_on && ic_req_addr == pred_pc;
    pred_target = pred_tgt;
    #1;
    hs = ic_req_valid && ic_req_ready;
    a = ic_req_addr;
    if (hs) req_log.push_back(a);
    if (valid_o && ready_i) begin
      b = '{pc_o, instruction_o, taken_branch_o};
      beat_log.push_back(b);
    end
    @(posedge clk);
    #1;
    if (ic_resp_valid) dummy = pending.pop_front();
    if (hs) pending.push_back(a);
    ic_resp_valid = resp_en && pending.size() > 0;
    ic_resp_data = ic_resp_valid ? data_of(pending[0]) : '0;
  endtask

  task automatic do_reset();
    rst = 1;
    {invalid_instruction, invalid_prediction, is_return, is_jumpl, must_flush, ic_resp_valid} = '0;
    pending.delete();
    req_log.delete();
    beat_log.delete();
    pred_on = 0;
    resp_en = 1;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    ic_req_ready = 1;
    @(posedge clk);
    #1;
    check("rst_req_valid", 32'(ic_req_valid), 0);
    check("rst_req_addr", ic_req_addr, 0);
    check("rst_valid_o", 32'(valid_o), 0);
    check("rst_pc_o", pc_o, 0);
    check("rst_instr", instruction_o, 0);
    check("rst_taken", 32'(taken_branch_o), 0);
    rst = 0;
    #1;
    check("first_req_valid", 32'(ic_req_valid), 1);
  endtask

  task automatic test_sequential();
    do_reset();
    ic_req_ready = 1;
    ready_i = 1;
    repeat (6) tick();
    check("seq_req1", req_log[1], 32'h4);
    check("seq_pc0", beat_log[0].pc, 32'h0);
    check("seq_pc1", beat_log[1].pc, 32'h4);
    check("seq_pc2", beat_log[2].pc, 32'h8);
    check("seq_instr1", beat_log[1].instr, data_of(32'h4));
  endtask

  task automatic test_backpressure();
    do_reset();
    ic_req_ready = 1;
    ready_i = 0;
    repeat (10) tick();
    #2;
    check("bp_req_count", 32'(req_log.size()), 4);
    check("bp_req_valid", 32'(ic_req_valid), 0);
    check("bp_valid_o", 32'(valid_o), 1);
    ready_i = 1;
    repeat (4) tick();
    check("bp_beat_count", 32'(beat_log.size()), 4);
    for (int i = 0; i < 4; i++) check($sformatf("bp_pc%0d", i), beat_log[i].pc, 32'(4 * i));
  endtask

  task automatic test_pred_taken();
    do_reset();
    pred_on = 1;
    pred_pc = 32'h8;
    pred_tgt = 32'h100;
    ic_req_ready = 1;
    ready_i = 1;
    repeat (8) tick();
    check("pt_req3", req_log[3], 32'h100);
    check("pt_req4", req_log[4], 32'h104);
    check("pt_taken_8", 32'(beat_log[2].taken), 1);
    check("pt_taken_4", 32'(beat_log[1].taken), 0);
    check("pt_pc3", beat_log[3].pc, 32'h100);
  endtask

  task automatic test_mispredict();
    do_reset();
    ic_req_ready = 1;
    ready_i = 0;
    tick();
    resp_en = 0;
    tick();
    tick();
    ic_req_ready = 0;
    ready_i = 1;
    invalid_prediction = 1;
    old_pc = 32'h8;
    resp_en = 1;
    tick();
    invalid_prediction = 0;
    ic_req_ready = 1;
    #2;
    check("mp_req_valid", 32'(ic_req_valid), 1);
    check("mp_req_addr", ic_req_addr, 32'hC);
    check("mp_valid_o", 32'(valid_o), 0);
    repeat (5) tick();
    check("mp_next_pc", beat_log[1].pc, 32'hC);
    check("mp_next_instr", beat_log[1].instr, data_of(32'hC));
  endtask

  task automatic test_return_flush();
    int n;
    do_reset();
    ic_req_ready = 1;
    ready_i = 1;
    tick();
    tick();
    is_return = 1;
    tick();
    is_return = 0;
    #2;
    check("ret_req_valid", 32'(ic_req_valid), 0);
    check("ret_valid_o", 32'(valid_o), 0);
    n = req_log.size();
    repeat (4) tick();
    check("ret_no_req", 32'(req_log.size()), 32'(n));
    must_flush = 1;
    correct_address = 32'h200;
    tick();
    must_flush = 0;
    #2;
    check("fl_req_addr", ic_req_addr, 32'h200);
    check("fl_req_valid", 32'(ic_req_valid), 1);
    repeat (4) tick();
    check("fl_pc", beat_log[1].pc, 32'h200);
  endtask

  task automatic test_halt();
    do_reset();
    ic_req_ready = 1;
    ready_i = 1;
    tick();
    tick();
    invalid_instruction = 1;
    tick();
    invalid_instruction = 0;
    #2;
    check("halt_valid_o", 32'(valid_o), 0);
    check("halt_req_valid", 32'(ic_req_valid), 0);
    invalid_prediction = 1;
    old_pc = 32'h500;
    repeat (3) tick();
    #2;
    check("halt_ignore_mp", 32'(ic_req_valid), 0);
    must_flush = 1;
    correct_address = 32'h40;
    tick();
    must_flush = 0;
    invalid_prediction = 0;
    repeat (4) tick();
    check("halt_flush_pc", beat_log[1].pc, 32'h40);
  endtask

  task automatic test_wrap();
    do_reset();
    ic_req_ready = 1;
    ready_i = 1;
    tick();
    is_jumpl = 1;
    must_flush = 1;
    correct_address = 32'hFFFF_FFFC;
    tick();
    is_jumpl = 0;
    must_flush = 0;
    repeat (3) tick();
    check("wrap_req_hi", req_log[1], 32'hFFFF_FFFC);
    check("wrap_req_lo", req_log[2], 32'h0);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_pred_taken();
    test_mispredict();
    test_return_flush();
    test_halt();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
